// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Purpose  : Shared types and geometry helpers for the image scan sequencer.
//            Provides the scan state encoding, default frame geometry and the
//            width helpers used to size row, column-pair and address ports.
// Revision : 1.0  initial release
// ============================================================================
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_DONE   = 3'd4
  } scan_state_t;

  localparam int IMG_W_DEF = 768;
  localparam int IMG_H_DEF = 512;

  // $clog2 of 1 is 0; keep every vector at least one bit wide.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_w(input int h);
    return clog2_min1(h);
  endfunction

  function automatic int col_w(input int w);
    return clog2_min1(w / 2);
  endfunction

  function automatic int addr_w(input int w, input int h);
    return clog2_min1(w * h);
  endfunction

  localparam int RW_DEF = row_w(IMG_H_DEF);
  localparam int CW_DEF = col_w(IMG_W_DEF);
  localparam int AW_DEF = addr_w(IMG_W_DEF, IMG_H_DEF);

endpackage
`default_nettype wire

// File: rtl/delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : delay_counter
// Purpose  : Loadable saturating down-counter with a zero flag. Shared by the
//            vertical preamble and the horizontal blanking intervals.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-low
//            load       - load load_value this cycle (takes priority)
//            load_value - value loaded into the counter
//            zero       - counter currently reads zero
// Revision : 1.0  initial release
// ============================================================================
module delay_counter
  import scan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/image_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : image_scan_ctrl
// Purpose  : Frame scan sequencer. On start it emits a vsync preamble, then one
//            hsync strobe per even/odd pixel pair with blanking between lines,
//            then a one-cycle frame_done. Supplies row / column-pair position
//            and even/odd pixel indices, and stalls on sink_ready = 0.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-low
//            start      - frame request, honoured only in IDLE
//            sink_ready - downstream accepts a pair this cycle
//            vsync      - high during the preamble
//            hsync      - pair valid strobe (ACTIVE qualified by sink_ready)
//            row        - current line
//            col_pair   - pair index within the line
//            even_addr  - pixel index of the even pixel
//            odd_addr   - even_addr + 1
//            busy       - high in every state except IDLE
//            frame_done - one-cycle pulse at frame end
// Revision : 1.0  initial release
// ============================================================================
module image_scan_ctrl
  import scan_pkg::*;
#(
  parameter int IMAGE_WIDTH  = IMG_W_DEF,
  parameter int IMAGE_HEIGHT = IMG_H_DEF,
  parameter int START_DELAY  = 100,
  parameter int HBLANK       = 160
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        sink_ready,
  output logic                                        vsync,
  output logic                                        hsync,
  output logic [row_w(IMAGE_HEIGHT)-1:0]              row,
  output logic [col_w(IMAGE_WIDTH)-1:0]               col_pair,
  output logic [addr_w(IMAGE_WIDTH, IMAGE_HEIGHT)-1:0] even_addr,
  output logic [addr_w(IMAGE_WIDTH, IMAGE_HEIGHT)-1:0] odd_addr,
  output logic                                        busy,
  output logic                                        frame_done
);

  localparam int RW   = row_w(IMAGE_HEIGHT);
  localparam int CW   = col_w(IMAGE_WIDTH);
  localparam int AW   = addr_w(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int DMAX = (START_DELAY > HBLANK) ? START_DELAY : HBLANK;
  localparam int DW   = clog2_min1(DMAX);

  localparam logic [RW-1:0] ROW_LAST   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_WIDTH / 2 - 1);
  localparam logic [AW-1:0] ADDR_STEP  = AW'(2);
  localparam logic [DW-1:0] VS_LOAD    = DW'(START_DELAY - 1);
  localparam logic [DW-1:0] HB_LOAD    = DW'(HBLANK - 1);

  scan_state_t   state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] even_q, even_d;
  logic [AW-1:0] odd_q, odd_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          dly_load;
  logic [DW-1:0] dly_value;
  logic          dly_zero;

  delay_counter #(
    .WIDTH (DW)
  ) u_delay (
    .clk        (clk),
    .reset      (reset),
    .load       (dly_load),
    .load_value (dly_value),
    .zero       (dly_zero)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    even_d    = even_q;
    dly_load  = 1'b0;
    dly_value = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_VSYNC;
          dly_load  = 1'b1;
          dly_value = VS_LOAD;
          row_d     = '0;
          col_d     = '0;
          even_d    = '0;
        end
      end

      ST_VSYNC: begin
        if (dly_zero) begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (sink_ready) begin
          // Lines are contiguous in memory, so the address simply steps by
          // one pair on every accepted pair, including across a line wrap.
          even_d = even_q + ADDR_STEP;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d   = ST_HBLANK;
              dly_load  = 1'b1;
              dly_value = HB_LOAD;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      ST_HBLANK: begin
        if (dly_zero) begin
          state_d = ST_ACTIVE;
          row_d   = row_q + RW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        row_d   = '0;
        col_d   = '0;
        even_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output flags are decoded from the next state so they are registered
    // in step with the state itself.
    odd_d    = even_d + AW'(1);
    vsync_d  = (state_d == ST_VSYNC);
    active_d = (state_d == ST_ACTIVE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      even_q   <= '0;
      odd_q    <= '0;
      vsync_q  <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      even_q   <= even_d;
      odd_q    <= odd_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // A pair is offered only when the writer can take it in the same cycle,
  // so the registered ACTIVE flag is qualified by sink_ready.
  assign hsync      = active_q & sink_ready;
  assign vsync      = vsync_q;
  assign row        = row_q;
  assign col_pair   = col_q;
  assign even_addr  = even_q;
  assign odd_addr   = odd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_image_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_scan_ctrl
// Purpose  : Self-checking bench for image_scan_ctrl at W=8, H=4,
//            START_DELAY=3, HBLANK=2. A frame is modelled as an ordered list
//            of slots (preamble, pairs, blanking, done); pair slots are only
//            consumed on cycles where sink_ready is high.
// Revision : 1.0  initial release
// ============================================================================
module tb_image_scan_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int SD = 3;
  localparam int HB = 2;

  localparam int K_VS   = 0;
  localparam int K_PAIR = 1;
  localparam int K_HB   = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int r;
    int c;
    int a;
  } slot_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sink_ready;
  logic       vsync;
  logic       hsync;
  logic [1:0] row;
  logic [1:0] col_pair;
  logic [4:0] even_addr;
  logic [4:0] odd_addr;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;
  slot_t slots[$];

  image_scan_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .START_DELAY  (SD),
    .HBLANK       (HB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sink_ready (sink_ready),
    .vsync      (vsync),
    .hsync      (hsync),
    .row        (row),
    .col_pair   (col_pair),
    .even_addr  (even_addr),
    .odd_addr   (odd_addr),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame as a list of slots, derived directly from the frame rules.
  function automatic void build_slots();
    slot_t s;
    slots.delete();
    for (int i = 0; i < SD; i++) begin
      s = '{K_VS, 0, 0, 0};
      slots.push_back(s);
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W / 2; c++) begin
        s = '{K_PAIR, r, c, r * W + 2 * c};
        slots.push_back(s);
      end
      if (r < H - 1) begin
        for (int b = 0; b < HB; b++) begin
          s = '{K_HB, r, 0, 0};
          slots.push_back(s);
        end
      end
    end
    s = '{K_DONE, 0, 0, 0};
    slots.push_back(s);
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_vsync"}, 32'(vsync), 0);
    check_eq({tag, "_hsync"}, 32'(hsync), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(frame_done), 0);
    check_eq({tag, "_row"}, 32'(row), 0);
    check_eq({tag, "_col"}, 32'(col_pair), 0);
    check_eq({tag, "_even"}, 32'(even_addr), 0);
    check_eq({tag, "_odd"}, 32'(odd_addr), 0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sink_ready = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_vsync", 32'(vsync), 0);
      check_eq("idle_done", 32'(frame_done), 0);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: 5-cycle stall at pair
  // (1,2); 3: reset asserted in the first blanking cycle after line 1.
  // Called with clk low; start is raised now and sampled on the next edge.
  task automatic do_frame(input int mode, input bit hold_start,
                          output int done_cycle, output int stalls);
    int    p;
    int    cyc;
    int    stall_left;
    bit    rdy;
    slot_t s;
    build_slots();
    p          = 0;
    cyc        = 0;
    stall_left = 5;
    stalls     = 0;
    done_cycle = -1;
    start      = 1'b1;
    while (p < slots.size()) begin
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      cyc++;
      s = slots[p];
      case (mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2: begin
          rdy = 1'b1;
          if (s.kind == K_PAIR && s.r == 1 && s.c == 2 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end
        end
        default: rdy = 1'b1;
      endcase
      sink_ready = rdy;
      if (mode == 3 && s.kind == K_HB && s.r == 1) begin
        reset = 1'b0;
        #1;
        check_all_zero("rst_async");
        return;
      end
      @(negedge clk);
      check_eq("busy", 32'(busy), 1);
      check_eq("vsync", 32'(vsync), 32'(s.kind == K_VS));
      check_eq("frame_done", 32'(frame_done), 32'(s.kind == K_DONE));
      check_eq("hsync", 32'(hsync), 32'(s.kind == K_PAIR && rdy));
      if (s.kind == K_PAIR) begin
        check_eq("row", 32'(row), 32'(s.r));
        check_eq("col_pair", 32'(col_pair), 32'(s.c));
        check_eq("even_addr", 32'(even_addr), 32'(s.a));
        check_eq("odd_addr", 32'(odd_addr), 32'(s.a + 1));
        if (!rdy) stalls++;
      end
      if (frame_done) done_cycle = cyc;
      if (!(s.kind == K_PAIR && !rdy)) p++;
    end
  endtask

  initial begin
    int dc;
    int st;

    reset      = 1'b0;
    start      = 1'b0;
    sink_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Basic frame, ready held high.
    do_frame(0, 1'b0, dc, st);
    check_eq("basic_done_cycle", 32'(dc), 26);
    idle_check(4);

    // Back-pressure at pair (1,2).
    do_frame(2, 1'b0, dc, st);
    check_eq("stall_done_cycle", 32'(dc), 31);
    idle_check(3);

    // Random back-pressure; each stalled pair cycle adds one cycle.
    for (int k = 0; k < 4; k++) begin
      do_frame(1, 1'b0, dc, st);
      check_eq("rand_done_cycle", 32'(dc), 32'(26 + st));
      idle_check(2);
    end

    // start held through ACTIVE and DONE, then into IDLE.
    do_frame(0, 1'b1, dc, st);
    check_eq("hold_done_cycle", 32'(dc), 26);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("gap_busy", 32'(busy), 0);
    check_eq("gap_done", 32'(frame_done), 0);
    do_frame(0, 1'b0, dc, st);
    check_eq("restart_done_cycle", 32'(dc), 26);
    idle_check(6);

    // Reset in the blanking after line 1.
    do_frame(3, 1'b0, dc, st);
    repeat (2) begin
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    idle_check(3);
    do_frame(0, 1'b0, dc, st);
    check_eq("post_reset_done_cycle", 32'(dc), 26);
    idle_check(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
